// File: rtl/usrt_pkg.sv
// Shared constants for the USRT controller: register map, STATUS/CTRL bit
// positions, FSM state codes and the divisor helper.
package usrt_pkg;

    localparam logic [1:0] ADDR_DATA = 2'd0;
    localparam logic [1:0] ADDR_STAT = 2'd1;
    localparam logic [1:0] ADDR_CTRL = 2'd2;
    localparam logic [1:0] ADDR_BAUD = 2'd3;

    localparam int STAT_TX_BUSY  = 0;
    localparam int STAT_RX_VALID = 1;
    localparam int STAT_RX_OVR   = 2;
    localparam int STAT_RX_FERR  = 3;

    localparam int CTRL_EN  = 0;
    localparam int CTRL_CLR = 1;

    localparam logic [1:0] TX_IDLE  = 2'd0;
    localparam logic [1:0] TX_LOAD  = 2'd1;
    localparam logic [1:0] TX_SHIFT = 2'd2;
    localparam logic [1:0] TX_STOP  = 2'd3;

    localparam logic [1:0] RX_IDLE  = 2'd0;
    localparam logic [1:0] RX_SHIFT = 2'd1;
    localparam logic [1:0] RX_STOP  = 2'd2;

    // A programmed divisor of 0 behaves like 1 (tick every cycle).
    function automatic logic [7:0] eff_div(input logic [7:0] d);
        return (d == 8'd0) ? 8'd1 : d;
    endfunction

endpackage

// File: rtl/usrt_bit_timer.sv
// Bit-clock divider: pulses bit_tick once every eff_div(div) cycles while en=1.
module usrt_bit_timer
    import usrt_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       en,
    input  logic       restart,
    input  logic [7:0] div,
    output logic       bit_tick
);

    logic [7:0] cnt_q, cnt_d;
    logic       tick_q, tick_d;

    // NOTE: every variable assigned here gets a default first, so no latch is inferred.
    always_comb begin
        cnt_d  = cnt_q + 8'd1;
        tick_d = 1'b0;
        if (!en || restart) begin
            cnt_d = '0;
        end else if (cnt_q >= eff_div(div) - 8'd1) begin
            cnt_d  = '0;
            tick_d = 1'b1;
        end
    end

    // NOTE: state updates use non-blocking assignments so all flops sample together.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q  <= '0;
            tick_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            tick_q <= tick_d;
        end
    end

    // Gate with en so a tick registered just before disable never escapes.
    assign bit_tick = tick_q & en;

endmodule

// File: rtl/usrt_apb_ctrl.sv
// APB slave for the USRT: register file, bit timer and the TX/RX frame FSMs
// that drive the serializer and deserializer handshakes.
module usrt_apb_ctrl
    import usrt_pkg::*;
#(
    parameter int         ADDR_W  = 8,
    parameter logic [7:0] DIV_RST = 8'd4
) (
    input  logic              pClk,
    input  logic              pReset,
    input  logic              pSelect,
    input  logic              pEnable,
    input  logic              pWrite,
    input  logic [ADDR_W-1:0] pAddress,
    input  logic [7:0]        pWData,
    output logic [7:0]        pRData,
    output logic              pReady,
    output logic              pSlvErr,
    output logic              tx_load,
    output logic [7:0]        tx_data,
    output logic              tx_shift,
    input  logic              rx_line,
    output logic              rx_shift,
    input  logic [7:0]        rx_data,
    output logic              bit_tick
);

    logic       en_q, en_d;
    logic [7:0] baud_q, baud_d;
    logic [7:0] tx_data_q, tx_data_d;
    logic [1:0] tx_state_q, tx_state_d;
    logic [2:0] tx_cnt_q, tx_cnt_d;
    logic [1:0] rx_state_q, rx_state_d;
    logic [2:0] rx_cnt_q, rx_cnt_d;
    logic [7:0] rx_hold_q, rx_hold_d;
    logic       rx_valid_q, rx_valid_d;
    logic       rx_ovr_q, rx_ovr_d;
    logic       rx_ferr_q, rx_ferr_d;

    logic [1:0] addr;
    logic       access, wr, rd, tx_busy, ctrl_wr, baud_wr, data_rd, abort;
    logic       rx_capture, rx_bad;
    logic [7:0] stat;
    logic       unused_addr;

    assign addr        = pAddress[1:0];
    assign unused_addr = ^pAddress;
    assign access      = pSelect & pEnable;
    assign wr          = access & pWrite;
    assign rd          = access & ~pWrite;
    assign tx_busy     = (tx_state_q != TX_IDLE);
    assign ctrl_wr     = wr && (addr == ADDR_CTRL);
    assign baud_wr     = wr && (addr == ADDR_BAUD);
    assign data_rd     = rd && (addr == ADDR_DATA);
    assign abort       = ctrl_wr && !pWData[CTRL_EN];

    usrt_bit_timer u_bit_timer (
        .clk      (pClk),
        .rst      (pReset),
        .en       (en_q),
        .restart  (baud_wr),
        .div      (baud_q),
        .bit_tick (bit_tick)
    );

    always_comb begin
        en_d       = en_q;
        baud_d     = baud_q;
        tx_data_d  = tx_data_q;
        tx_state_d = tx_state_q;
        tx_cnt_d   = tx_cnt_q;
        rx_state_d = rx_state_q;
        rx_cnt_d   = rx_cnt_q;
        rx_hold_d  = rx_hold_q;
        rx_valid_d = rx_valid_q;
        rx_ovr_d   = rx_ovr_q;
        rx_ferr_d  = rx_ferr_q;
        rx_capture = 1'b0;
        rx_bad     = 1'b0;

        if (ctrl_wr) begin
            en_d = pWData[CTRL_EN];
            if (pWData[CTRL_CLR]) begin
                rx_ovr_d  = 1'b0;
                rx_ferr_d = 1'b0;
            end
        end
        if (baud_wr) baud_d = pWData;

        case (tx_state_q)
            TX_IDLE: if (wr && addr == ADDR_DATA) begin
                tx_data_d  = pWData;
                tx_state_d = TX_LOAD;
            end
            TX_LOAD: if (bit_tick) begin
                tx_state_d = TX_SHIFT;
                tx_cnt_d   = '0;
            end
            TX_SHIFT: if (bit_tick) begin
                tx_cnt_d = tx_cnt_q + 3'd1;
                if (tx_cnt_q == 3'd7) tx_state_d = TX_STOP;
            end
            default: if (bit_tick) tx_state_d = TX_IDLE;
        endcase

        case (rx_state_q)
            RX_IDLE: if (bit_tick && !rx_line) begin
                rx_state_d = RX_SHIFT;
                rx_cnt_d   = '0;
            end
            RX_SHIFT: if (bit_tick) begin
                rx_cnt_d = rx_cnt_q + 3'd1;
                if (rx_cnt_q == 3'd7) rx_state_d = RX_STOP;
            end
            RX_STOP: if (bit_tick) begin
                rx_state_d = RX_IDLE;
                rx_capture = rx_line;
                rx_bad     = !rx_line;
            end
            default: rx_state_d = RX_IDLE;
        endcase

        if (abort) begin
            tx_state_d = TX_IDLE;
            tx_cnt_d   = '0;
            rx_state_d = RX_IDLE;
            rx_cnt_d   = '0;
        end

        // A read-clear in the capture cycle makes room for the new byte.
        if (data_rd) rx_valid_d = 1'b0;
        if (rx_bad) rx_ferr_d = 1'b1;
        if (rx_capture) begin
            if (!rx_valid_q || data_rd) begin
                rx_hold_d  = rx_data;
                rx_valid_d = 1'b1;
            end else begin
                rx_ovr_d = 1'b1;
            end
        end
    end

    always_ff @(posedge pClk or posedge pReset) begin
        if (pReset) begin
            en_q       <= 1'b0;
            baud_q     <= DIV_RST;
            tx_data_q  <= '0;
            tx_state_q <= TX_IDLE;
            tx_cnt_q   <= '0;
            rx_state_q <= RX_IDLE;
            rx_cnt_q   <= '0;
            rx_hold_q  <= '0;
            rx_valid_q <= 1'b0;
            rx_ovr_q   <= 1'b0;
            rx_ferr_q  <= 1'b0;
        end else begin
            en_q       <= en_d;
            baud_q     <= baud_d;
            tx_data_q  <= tx_data_d;
            tx_state_q <= tx_state_d;
            tx_cnt_q   <= tx_cnt_d;
            rx_state_q <= rx_state_d;
            rx_cnt_q   <= rx_cnt_d;
            rx_hold_q  <= rx_hold_d;
            rx_valid_q <= rx_valid_d;
            rx_ovr_q   <= rx_ovr_d;
            rx_ferr_q  <= rx_ferr_d;
        end
    end

    always_comb begin
        stat                = '0;
        stat[STAT_TX_BUSY]  = tx_busy;
        stat[STAT_RX_VALID] = rx_valid_q;
        stat[STAT_RX_OVR]   = rx_ovr_q;
        stat[STAT_RX_FERR]  = rx_ferr_q;
        pRData              = '0;
        if (access) begin
            case (addr)
                ADDR_DATA: pRData = rx_hold_q;
                ADDR_STAT: pRData = stat;
                ADDR_CTRL: pRData = {7'd0, en_q};
                default:   pRData = baud_q;
            endcase
        end
    end

    assign pReady   = access;
    assign pSlvErr  = wr && ((addr == ADDR_STAT) || (addr == ADDR_DATA && tx_busy));
    assign tx_data  = tx_data_q;
    assign tx_load  = (tx_state_q == TX_LOAD) && bit_tick;
    assign tx_shift = (tx_state_q == TX_SHIFT) && bit_tick;
    assign rx_shift = (rx_state_q == RX_SHIFT) && bit_tick;

endmodule

// File: doc/usrt_apb_ctrl.md
# usrt_apb_ctrl

APB-slave controller that sequences the USRT datapath: a small register file, the serial bit-clock enable, and the TX/RX frame state machines. It drives the serializer (load/shift) and deserializer (shift/capture) handshakes. Bus access, bit timing and framing are handled in one block, so the shift registers stay purely datapath.

## Interface
Parameters:
- ADDR_W, 8, APB address width; only pAddress[1:0] is decoded.
- DIV_RST, 8'd4, reset value of the BAUD register.

Ports:
- pClk  in  1  system clock; all logic is on the rising edge.
- pReset  in  1  asynchronous, active-high reset.
- pSelect, pEnable, pWrite  in  1 each  APB control.
- pAddress  in  ADDR_W  register address.
- pWData  in  8  write data.
- pRData  out  8  read data.
- pReady  out  1  transfer complete.
- pSlvErr  out  1  error on the current access phase.
- tx_load  out  1  one-cycle pulse: serializer loads tx_data.
- tx_data  out  8  TX holding register.
- tx_shift  out  1  serializer shift enable, one cycle per bit.
- rx_line  in  1  serial input, used for start/stop detection.
- rx_shift  out  1  deserializer shift enable.
- rx_data  in  8  deserializer parallel output.
- bit_tick  out  1  bit-clock enable, exported as uClk qualifier.

## Operation
- Registers (pAddress[1:0]):
  - 0 DATA: write loads TX holding; read returns RX holding.
  - 1 STATUS, RO: {4'b0, rx_ferr, rx_ovr, rx_valid, tx_busy}.
  - 2 CTRL: bit0 en; bit1 write-1-clears rx_ovr/rx_ferr.
  - 3 BAUD: 8-bit divisor; 0 is treated as 1.
- APB access:
  - An access completes on a cycle with pSelect & pEnable.
  - No wait states: pReady = pSelect & pEnable.
  - pRData is combinational from the address; it is 0 outside the access phase.
- Bit clock:
  - An 8-bit counter runs only while en=1; bit_tick pulses one cycle every max(BAUD,1) pClk cycles.
  - en=0 clears the counter.
  - A BAUD write restarts the counter.
- TX FSM, states IDLE, LOAD, SHIFT, STOP:
  - A DATA write while tx_busy=0 sets tx_busy and moves IDLE to LOAD.
  - LOAD: on the next bit_tick, pulse tx_load and enter SHIFT.
  - SHIFT: assert tx_shift on 8 consecutive ticks (3-bit counter), then enter STOP.
  - STOP: one tick, then IDLE and tx_busy clears.
  - A DATA write while tx_busy=1 is dropped and pSlvErr=1 for that access.
- RX FSM, states IDLE, SHIFT, STOP:
  - IDLE: on a bit_tick with rx_line=0 (start bit), enter SHIFT.
  - SHIFT: assert rx_shift on 8 ticks.
  - STOP: on the next tick, sample rx_line. 0 sets rx_ferr and discards the byte; 1 captures rx_data.
  - On capture with rx_valid=0: load RX holding and set rx_valid.
  - On capture with rx_valid=1: set rx_ovr; the old byte is kept.
  - A DATA read clears rx_valid at access completion.
  - Read-clear and capture in the same cycle: new byte loads, rx_valid stays 1, no overrun.
- Writing en=0 aborts both FSMs to IDLE and clears tx_busy; holding registers and flags are kept.
- Accesses to undefined bits are ignored. Writes to STATUS set pSlvErr.

## Timing
- Reset values:
  - pRData=0, pReady=0, pSlvErr=0.
  - tx_load=tx_shift=rx_shift=bit_tick=0, tx_data=0.
  - CTRL=0, BAUD=DIV_RST, STATUS=0, both FSMs in IDLE.
- Reset asserted mid-frame forces all of the above immediately, without waiting for a clock.
- A register write takes effect on the completing edge and is visible on the next access.
- TX latency, DATA write to first tx_shift: 1 to BAUD+1 cycles to the first tick (tx_load), then BAUD cycles more.
- A TX frame occupies 10 ticks (LOAD + 8 SHIFT + STOP). tx_busy is 1 from the cycle after the write until the cycle after the STOP tick.
- RX: rx_valid rises the cycle after the STOP tick.
- tx_load and tx_shift are never asserted in the same cycle.

## Structure
- Shared package usrt_pkg holds:
  - register address constants (ADDR_DATA=0, ADDR_STAT=1, ADDR_CTRL=2, ADDR_BAUD=3);
  - STATUS/CTRL bit indices;
  - TX and RX state enumerations.
- One sub-module, usrt_bit_timer: divisor counter producing bit_tick, with en and restart inputs.
- The FSMs and register file stay in usrt_apb_ctrl.

## Test plan
- Reset, then read all 4 registers → 0x00, 0x00, 0x00, 0x04. pReady=1 in each access phase and pSlvErr=0.
- BAUD=2, en=1, write DATA=0xA5:
  - one tx_load, then exactly 8 tx_shift pulses 2 cycles apart, tx_data=0xA5;
  - STATUS=0x01 during the frame, 0x00 after STOP.
- A second DATA write during the frame → pSlvErr=1; tx_data stays 0xA5; only one frame is sent.
- RX sequence start 0, 8 shifts, rx_line=1 at stop, with rx_data=0x3C → STATUS=0x02; DATA read returns 0x3C, after which STATUS=0x00.
- Two frames received without a read → STATUS=0x06 and DATA=first byte.
  - A stop bit of 0 sets bit 3 (rx_ferr).
  - Writing CTRL=0x03 clears bits 2-3 and keeps en.
- Clear en mid-TX-frame → no further tx_shift; tx_busy=0 next cycle. Assert pReset mid-frame → all outputs at reset values immediately.
